// File: rtl/seq_digit_adder.sv
// seq_digit_adder: multi-cycle adder that consumes DIGIT bits per clock, LSB digit first.
// A DIGIT-bit ripple slice plus a registered carry walks the operands over STEPS cycles.
// Handshake: start is accepted whenever busy = 0; done pulses for one cycle with the result.
// Optional build macro SEQ_ADDER_SUB_EN adds a 'sub' input that turns the block into A - B.

module seq_digit_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             carry_in,
`ifdef SEQ_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned STEPS = WIDTH / DIGIT;
   localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT:0]   slice;
   logic             msb_cin;
   logic [WIDTH-1:0] acc_shift;
   logic             last_step;
   logic             accept;
   logic [WIDTH-1:0] b_cap;
   logic             cin_cap;

   // Ripple slice over the current digit; carry into the slice MSB is recovered from its sum bit
   always_comb begin
      slice     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      msb_cin   = slice[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
      acc_shift = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
      last_step = (cnt_q == CW'(STEPS - 1));
   end

   // Operand capture; subtraction is A + ~B + 1
   always_comb begin
`ifdef SEQ_ADDER_SUB_EN
      b_cap   = sub ? ~op_b : op_b;
      cin_cap = sub | carry_in;
`else
      b_cap   = op_b;
      cin_cap = carry_in;
`endif
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            busy = 1'b1;
            if (last_step) state_d = StDone;
         end
         StDone: begin
            done = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next state: capture on accept, shift one digit per RUN cycle, publish on the last
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = op_a;
         b_d     = b_cap;
         carry_d = cin_cap;
         cnt_d   = '0;
      end else if (state_q == StRun) begin
         a_d     = a_q >> DIGIT;
         b_d     = b_q >> DIGIT;
         carry_d = slice[DIGIT];
         acc_d   = acc_shift;
         cnt_d   = cnt_q + 1'b1;
         if (last_step) begin
            cnt_d  = '0;
            sum_d  = acc_shift;
            cout_d = slice[DIGIT];
            ovf_d  = slice[DIGIT] ^ msb_cin;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_digit_adder.sv
// Directed bench for seq_digit_adder: default 16/4 instance plus an 8/8 single-step instance.

module tb_seq_digit_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, carry_in;
   logic [15:0] op_a, op_b;
   logic        busy, done, carry_out, overflow;
   logic [15:0] sum;
`ifdef SEQ_ADDER_SUB_EN
   logic        sub;
`endif

   logic        start8, cin8;
   logic [7:0]  op_a8, op_b8;
   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  sum8;

   int total = 0;
   int bad   = 0;

   seq_digit_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .carry_in  (carry_in),
`ifdef SEQ_ADDER_SUB_EN
      .sub       (sub),
`endif
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   seq_digit_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .op_a      (op_a8),
      .op_b      (op_b8),
      .carry_in  (cin8),
`ifdef SEQ_ADDER_SUB_EN
      .sub       (1'b0),
`endif
      .busy      (busy8),
      .done      (done8),
      .sum       (sum8),
      .carry_out (cout8),
      .overflow  (ovf8)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        c;
      logic        o;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, exp);
      end
   endtask

   // Present operands with start high, let one edge accept them, then drop start
   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sv);
      @(negedge clk);
      op_a     = a;
      op_b     = b;
      carry_in = cin;
`ifdef SEQ_ADDER_SUB_EN
      sub      = sv;
`else
      if (sv) $display("note: sub requested but not built in");
`endif
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
   endtask

   // Count edges until done, tally busy cycles and any output change while running
   task automatic wait_done(output int lat, output int nbusy, output int npart);
      logic [15:0] s0;
      s0    = sum;
      lat   = 0;
      nbusy = busy ? 1 : 0;
      npart = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (!done) begin
            if (busy) nbusy++;
            if (sum !== s0) npart++;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sv, input logic [15:0] es,
                        input logic ec, input logic eo);
      int lat, nbusy, npart;
      launch(a, b, cin, sv);
      wait_done(lat, nbusy, npart);
      check({tag, " latency"}, lat, 4);
      check({tag, " busy_cycles"}, nbusy, 4);
      check({tag, " no_partial"}, npart, 0);
      check({tag, " sum"}, sum, es);
      check({tag, " carry_out"}, carry_out, ec);
      check({tag, " overflow"}, overflow, eo);
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " sum_hold"}, sum, es);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nbusy, npart, seen;
      logic [7:0] a8 [2];
      logic [7:0] b8 [2];
      logic       c8 [2];
      logic [7:0] s8 [2];
      logic       co8 [2];
      logic       ov8 [2];

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[6] = '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1};

      rst_n    = 1'b0;
      start    = 1'b0;
      op_a     = '0;
      op_b     = '0;
      carry_in = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      sub      = 1'b0;
`endif
      start8   = 1'b0;
      op_a8    = '0;
      op_b8    = '0;
      cin8     = 1'b0;

      #12;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset carry_out", carry_out, 0);
      check("reset overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
               vecs[i].s, vecs[i].c, vecs[i].o);
      end

      // start re-pulsed mid-RUN with other operands must be ignored
      launch(16'h1234, 16'h4321, 1'b0, 1'b0);
      op_a  = 16'hAAAA;
      op_b  = 16'h1111;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, nbusy, npart);
      check("ignore latency", lat, 3);
      check("ignore sum", sum, 16'h5555);
      check("ignore done", done, 1);

      // start held during DONE is accepted back-to-back
      op_a     = 16'h0001;
      op_b     = 16'h0002;
      carry_in = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b busy", busy, 1);
      wait_done(lat, nbusy, npart);
      check("b2b latency", lat, 4);
      check("b2b sum", sum, 16'h0003);
      check("b2b no_partial", npart, 0);

      // reset in the 2nd RUN cycle aborts the operation
      @(posedge clk);
      launch(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort sum", sum, 0);
      check("abort carry_out", carry_out, 0);
      check("abort overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("abort no_done", seen, 0);
      do_op("after_abort", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

      // single-step instance: DIGIT = WIDTH
      a8[0] = 8'h80; b8[0] = 8'h80; c8[0] = 1'b0; s8[0] = 8'h00; co8[0] = 1'b1; ov8[0] = 1'b1;
      a8[1] = 8'h3C; b8[1] = 8'h42; c8[1] = 1'b1; s8[1] = 8'h7F; co8[1] = 1'b0; ov8[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         op_a8  = a8[i];
         op_b8  = b8[i];
         cin8   = c8[i];
         start8 = 1'b1;
         @(posedge clk);
         #1;
         start8 = 1'b0;
         check($sformatf("w8_%0d busy", i), busy8, 1);
         lat = 0;
         while (!done8 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check($sformatf("w8_%0d latency", i), lat, 1);
         check($sformatf("w8_%0d sum", i), sum8, s8[i]);
         check($sformatf("w8_%0d carry_out", i), cout8, co8[i]);
         check($sformatf("w8_%0d overflow", i), ovf8, ov8[i]);
      end

`ifdef SEQ_ADDER_SUB_EN
      do_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      do_op("sub_off_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
